// File: rtl/imem_read_arbiter.sv
// Two-master, single-outstanding read arbiter for the instruction memory port.
// Demand refills (IC) win; a starvation counter bounds prefetch (SB) wait.
module imem_read_arbiter #(
   parameter int         ADDR_WIDTH   = 32,
   parameter int         DATA_WIDTH   = 32,
   parameter logic [3:0] IC_ID        = 4'd0,
   parameter logic [3:0] SB_ID        = 4'd2,
   parameter int         STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  ic_arvalid,
   input  logic [ADDR_WIDTH-1:0] ic_araddr,
   input  logic [3:0]            ic_arlen,
   output logic                  ic_arready,
   output logic                  ic_rvalid,
   input  logic                  ic_rready,

   input  logic                  sb_arvalid,
   input  logic [ADDR_WIDTH-1:0] sb_araddr,
   input  logic [3:0]            sb_arlen,
   output logic                  sb_arready,
   output logic                  sb_rvalid,
   input  logic                  sb_rready,

   output logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  m_rlast,

   output logic                  mem_arvalid,
   output logic [ADDR_WIDTH-1:0] mem_araddr,
   output logic [3:0]            mem_arlen,
   output logic [3:0]            mem_arid,
   input  logic                  mem_arready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rlast,
   output logic                  mem_rready,

   output logic                  protocol_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  owner;
   logic                  owner_nxt;
   logic [4:0]            beat_cnt;
   logic [4:0]            beat_nxt;
   logic [SW-1:0]         starve;
   logic [SW-1:0]         starve_nxt;
   logic                  err_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [3:0]            len_nxt;
   logic [3:0]            id_nxt;

   logic                  starved;
   logic                  grant_ic;
   logic                  grant_sb;
   logic                  hs;
   logic                  beat_match;

   // owner: 0 = IC, 1 = SB
   always_comb begin
      starved  = (starve == STARVE_MAX);
      grant_sb = rst_n && (state == IDLE) && sb_arvalid
                 && (!ic_arvalid || starved);
      grant_ic = rst_n && (state == IDLE) && ic_arvalid
                 && !grant_sb;
   end

   always_comb begin
      ic_arready  = grant_ic;
      sb_arready  = grant_sb;
      mem_arvalid = (state == ADDR);
      ic_rvalid   = 1'b0;
      sb_rvalid   = 1'b0;
      mem_rready  = 1'b1;
      if (state == DATA) begin
         if (owner) begin
            sb_rvalid  = mem_rvalid;
            mem_rready = sb_rready;
         end else begin
            ic_rvalid  = mem_rvalid;
            mem_rready = ic_rready;
         end
      end
   end

   assign m_rdata = mem_rdata;
   assign m_rlast = mem_rlast;

   always_comb begin
      hs         = (state == DATA) && mem_rvalid && mem_rready;
      beat_match = (beat_cnt == {1'b0, mem_arlen});
   end

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      beat_nxt   = beat_cnt;
      starve_nxt = starve;
      addr_nxt   = mem_araddr;
      len_nxt    = mem_arlen;
      id_nxt     = mem_arid;
      err_nxt    = protocol_err;
      unique case (state)
         IDLE: begin
            if (grant_sb) begin
               state_nxt  = ADDR;
               owner_nxt  = 1'b1;
               beat_nxt   = '0;
               starve_nxt = '0;
               addr_nxt   = sb_araddr;
               len_nxt    = sb_arlen;
               id_nxt     = SB_ID;
            end else if (grant_ic) begin
               state_nxt = ADDR;
               owner_nxt = 1'b0;
               beat_nxt  = '0;
               addr_nxt  = ic_araddr;
               len_nxt   = ic_arlen;
               id_nxt    = IC_ID;
               if (!sb_arvalid) begin
                  starve_nxt = '0;
               end else if (!starved) begin
                  starve_nxt = starve + SW'(1);
               end
            end
         end
         ADDR: begin
            if (mem_arready) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (hs) begin
               beat_nxt = beat_cnt + 5'd1;
               // rlast must coincide exactly with beat index == arlen
               if (mem_rlast != beat_match) begin
                  err_nxt = 1'b1;
               end
               if (mem_rlast) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= 1'b0;
         beat_cnt     <= '0;
         starve       <= '0;
         protocol_err <= 1'b0;
         mem_araddr   <= '0;
         mem_arlen    <= '0;
         mem_arid     <= '0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         beat_cnt     <= beat_nxt;
         starve       <= starve_nxt;
         protocol_err <= err_nxt;
         mem_araddr   <= addr_nxt;
         mem_arlen    <= len_nxt;
         mem_arid     <= id_nxt;
      end
   end

endmodule
